// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the EX stage and the mul/div unit.
//   master (pipeline side): drives start, op, a, b, mthi, mtlo; observes busy, done, hi, lo.
//   slave  (muldiv_unit)  : the mirror image.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine holding the HI/LO registers.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : muldiv_if slave port
//          start/op/a/b request an operation (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//          mthi/mtlo write a into HI/LO while idle
//          busy high while an operation runs, done pulses when HI/LO take a result
// An operation takes 33 cycles: 32 shift-add / restoring-divide iterations on
// operand magnitudes, then one cycle that applies the result signs and writes HI/LO.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         op_q, op_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    // Multiply: acc = {partial product, remaining multiplier bits}. Add the
    // multiplicand into the upper half when the current multiplier bit is set,
    // then shift the whole thing right; the carry lands in the top bit.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend bits shifting out / quotient bits shifting in}.
    // The shifted remainder needs one extra bit so the trial subtract cannot overflow.
    logic [WIDTH:0]     div_rem_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_step;
    assign div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff   = div_rem_sh - {1'b0, mag_b_q};
    assign div_step   = div_diff[WIDTH]
                      ? {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                      : {div_diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

    // Sign-corrected results, only consumed in FIX.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   a_orig;
    assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    assign quot_fix = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign a_orig   = neg_a_q ? -mag_a_q : mag_a_q;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        op_d    = op_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE: begin
                // MTHI/MTLO land at this edge; a result started now overwrites them later.
                if (bus.mthi) hi_d = bus.a;
                if (bus.mtlo) lo_d = bus.a;
                if (bus.start) begin
                    state_d = CALC;
                    op_d    = bus.op;
                    // op[0]==0 selects the signed variants
                    neg_a_d = ~bus.op[0] & bus.a[WIDTH-1];
                    neg_b_d = ~bus.op[0] & bus.b[WIDTH-1];
                    mag_a_d = neg_a_d ? -bus.a : bus.a;
                    mag_b_d = neg_b_d ? -bus.b : bus.b;
                    cnt_d   = '0;
                    acc_d   = bus.op[1] ? {{WIDTH{1'b0}}, mag_a_d} : {{WIDTH{1'b0}}, mag_b_d};
                end
            end
            CALC: begin
                acc_d = op_q[1] ? div_step : mul_step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!op_q[1]) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (mag_b_q == '0) begin
                    // Divide by zero: dividend passes to HI, LO saturates by dividend sign.
                    hi_d = a_orig;
                    lo_d = neg_a_q ? WIDTH'(1) : '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            op_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            op_q    <= op_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the MIPS datapath, downstream of the operand-B select stage in EX.
- Operand B is the selected Rt value; operand A is Rs.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and holds the results in architectural HI/LO registers.
- Raises busy so the pipeline can stall MFHI/MFLO and further mult/div ops. Also services MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is supported and verified.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  one-cycle request to begin the operation selected by op.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  32  operand A (Rs); dividend for DIV/DIVU.
- b  input  32  operand B (selected Rt); divisor for DIV/DIVU.
- mthi  input  1  write a into HI.
- mtlo  input  1  write a into LO.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when HI/LO receive a new result.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0, done=0, hi=0, lo=0.
  - All internal operand, accumulator and counter registers cleared.
  - Takes effect immediately, including mid-operation; the in-flight result is discarded.
- States:
  - IDLE: accept start.
  - CALC: 32 iteration cycles.
  - FIX: sign correction and HI/LO write, 1 cycle.
  - Transitions: IDLE->CALC on start; CALC->FIX when counter reaches 31; FIX->IDLE unconditionally.
- Latency and flags:
  - start sampled in IDLE at edge k latches a, b and op; busy=1 from edge k.
  - HI/LO updated at edge k+33; busy=0 and done=1 from edge k+33 for exactly one cycle.
  - A new start is accepted in the cycle done is high (state is IDLE).
- start while busy: ignored. No queuing, no error flag.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes at latch time; original signs are kept.
  - Result signs are applied in FIX.
- Multiply:
  - Shift-add, one bit of b per CALC cycle.
  - HI:LO = full 64-bit product.
- Divide:
  - Restoring, one quotient bit per CALC cycle.
  - LO = quotient, HI = remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (b=0):
  - HI = a, for both DIVU and DIV.
  - DIVU: LO = 32'hFFFFFFFF.
  - DIV: LO = 32'hFFFFFFFF if a >= 0, else 32'h00000001.
  - Same latency as a normal divide; busy/done behave as normal.
- Signed overflow (DIV 32'h80000000 / 32'hFFFFFFFF): LO = 32'h80000000, HI = 0.
- MTHI/MTLO:
  - In IDLE, mthi/mtlo write a into hi/lo at the next edge. Both may assert together.
  - Combined with start in the same cycle, the write applies at that edge and the later result overwrites it.
  - While busy, mthi/mtlo are ignored.
- hi/lo are stable at all times except on their write edges; outputs come straight from registers.

Test Plan:
- MULT a=32'hFFFFFFFD (-3), b=5 -> after 33 cycles done=1; hi=FFFFFFFF, lo=FFFFFFF1.
- MULTU a=b=32'hFFFFFFFF -> hi=FFFFFFFE, lo=00000001; busy high exactly 33 cycles.
- DIV a=32'hFFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU a=100, b=7 -> lo=0000000E, hi=00000002.
- Divide by zero:
  - DIVU a=1234, b=0 -> lo=FFFFFFFF, hi=000004D2.
  - DIV a=32'hFFFFFF00, b=0 -> lo=00000001, hi=FFFFFF00.
  - DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
- Busy interactions:
  - start MULTU 6*7; at cycle 10 pulse start with DIVU and pulse mthi with a=55 -> both ignored; final hi=0, lo=0000002A.
  - Back-to-back start during the done cycle is accepted.
- Reset: assert rst asynchronously at cycle 15 of a MULT -> busy, done, hi, lo go to 0 immediately. After release, MTLO a=9 in IDLE -> lo=9 next edge.
